// File: rtl/alu_issue_stage_pkg.sv
// Shared types and defaults for the decode-to-execute issue stage.
// Holds ALU opcodes, writeback result-source codes and forwarding-select codes.
package alu_issue_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/alu_issue_stage_fwd_sel.sv
// Operand forwarding mux for one source register: MEM beats WB beats the registered value.
// Register 0 never forwards, whatever the producer claims.
module fwd_sel
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [DATA_W-1:0] i_reg_val,
    input  logic [REG_AW-1:0] i_rd_m,
    input  logic              i_regwrite_m,
    input  logic [DATA_W-1:0] i_result_m,
    input  logic [REG_AW-1:0] i_rd_w,
    input  logic              i_regwrite_w,
    input  logic [DATA_W-1:0] i_result_w,
    output logic [DATA_W-1:0] o_val,
    output logic [1:0]        o_sel
);

    logic     w_hit_m;
    logic     w_hit_w;
    fwd_sel_e w_sel;

    assign w_hit_m = i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs);
    assign w_hit_w = i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs);

    always_comb begin
        // NOTE: defaults assigned first so every path drives both outputs; no latch is inferred.
        w_sel = FWD_REG;
        o_val = i_reg_val;
        if (w_hit_m) begin
            w_sel = FWD_M;
            o_val = i_result_m;
        end else if (w_hit_w) begin
            w_sel = FWD_W;
            o_val = i_result_w;
        end
    end

    assign o_sel = w_sel;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, flush and
// MEM/WB operand forwarding that survives a stall by re-latching forwarded operands.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] ImmExtD,
    input  logic [DATA_W-1:0] PCD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              ALUSrcD,
    input  logic [2:0]        ALUControlD,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              flush,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] SrcAE,
    output logic [DATA_W-1:0] SrcBE,
    output logic [DATA_W-1:0] WriteDataE,
    output logic [DATA_W-1:0] PCE,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [2:0]        ALUControlE,
    output logic [REG_AW-1:0] RdE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE
);

    logic              r_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic              r_alu_src;
    logic [2:0]        r_alu_ctrl;
    logic              r_regwrite;
    logic [1:0]        r_result_src;

    logic              w_accept;
    logic              w_hold;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;

    assign ready_out = !r_valid || ready_in;
    assign w_accept  = valid_in && ready_out;
    assign w_hold    = r_valid && !ready_in;

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .i_rs         (r_rs1),
        .i_reg_val    (r_a),
        .i_rd_m       (RdM),
        .i_regwrite_m (RegWriteM),
        .i_result_m   (ALUResultM),
        .i_rd_w       (RdW),
        .i_regwrite_w (RegWriteW),
        .i_result_w   (ResultW),
        .o_val        (w_fwd_a),
        .o_sel        (w_sel_a)
    );

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .i_rs         (r_rs2),
        .i_reg_val    (r_b),
        .i_rd_m       (RdM),
        .i_regwrite_m (RegWriteM),
        .i_result_m   (ALUResultM),
        .i_rd_w       (RdW),
        .i_regwrite_w (RegWriteW),
        .i_result_w   (ResultW),
        .o_val        (w_fwd_b),
        .o_sel        (w_sel_b)
    );

    // Flush wins over both accept and hold; otherwise an open slot takes whatever decode offers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (ready_out) begin
            r_valid <= valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_src    <= 1'b0;
            r_alu_ctrl   <= ALU_ADD;
            r_regwrite   <= 1'b0;
            r_result_src <= RES_ALU;
        end else if (w_accept) begin
            r_a          <= RD1D;
            r_b          <= RD2D;
            r_imm        <= ImmExtD;
            r_pc         <= PCD;
            r_rs1        <= Rs1D;
            r_rs2        <= Rs2D;
            r_rd         <= RdD;
            r_alu_src    <= ALUSrcD;
            r_alu_ctrl   <= ALUControlD;
            r_regwrite   <= RegWriteD;
            r_result_src <= ResultSrcD;
        end else if (w_hold) begin
            // Capture forwarded operands so they stay valid after the producer retires.
            if (w_sel_a != FWD_REG) r_a <= w_fwd_a;
            if (w_sel_b != FWD_REG) r_b <= w_fwd_b;
        end
    end

    assign valid_out   = r_valid;
    assign SrcAE       = w_fwd_a;
    assign WriteDataE  = w_fwd_b;
    assign SrcBE       = r_alu_src ? r_imm : w_fwd_b;
    assign PCE         = r_pc;
    assign ImmExtE     = r_imm;
    assign ALUControlE = r_alu_ctrl;
    assign RdE         = r_rd;
    assign RegWriteE   = r_regwrite && r_valid;
    assign ResultSrcE  = r_result_src;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: scoreboard for plain transfers plus directed
// forwarding, stall-refresh, flush and reset scenarios.
module tb_alu_issue_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] RD1D, RD2D, ImmExtD, PCD;
    logic [AW-1:0] Rs1D, Rs2D, RdD;
    logic          ALUSrcD;
    logic [2:0]    ALUControlD;
    logic          RegWriteD;
    logic [1:0]    ResultSrcD;
    logic          flush;
    logic [DW-1:0] ALUResultM, ResultW;
    logic [AW-1:0] RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
    logic [2:0]    ALUControlE;
    logic [AW-1:0] RdE;
    logic          RegWriteE;
    logic [1:0]    ResultSrcE;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .flush(flush), .ALUResultM(ALUResultM), .ResultW(ResultW),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ready_in(ready_in), .valid_out(valid_out),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .PCE(PCE),
        .ImmExtE(ImmExtE), .ALUControlE(ALUControlE), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] wd;
        logic [DW-1:0] pc;
        logic [2:0]    op;
        logic [AW-1:0] rd;
        logic          rw;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    logic sb_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    // Scoreboard monitor: a transfer happens at the next edge whenever valid_out && ready_in.
    always @(negedge clk) begin
        if (sb_en && rst && valid_out && ready_in) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_empty: transfer seen with no expected entry (SrcAE=%0h)", SrcAE);
            end else begin
                sb_e = sb_q.pop_front();
                if ({SrcAE, SrcBE, WriteDataE, PCE, ALUControlE, RdE, RegWriteE} !==
                    {sb_e.a, sb_e.b, sb_e.wd, sb_e.pc, sb_e.op, sb_e.rd, sb_e.rw})
                    $display("FAIL sb_xfer: got A=%0h B=%0h WD=%0h PC=%0h op=%0d rd=%0d rw=%0b expected A=%0h B=%0h WD=%0h PC=%0h op=%0d rd=%0d rw=%0b",
                             SrcAE, SrcBE, WriteDataE, PCE, ALUControlE, RdE, RegWriteE,
                             sb_e.a, sb_e.b, sb_e.wd, sb_e.pc, sb_e.op, sb_e.rd, sb_e.rw);
                else
                    n_pass++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ALUResultM = '0; ResultW = '0;
    endtask

    task automatic load_d(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] imm, input logic src,
                          input logic [2:0] op, input logic [AW-1:0] rd, input logic rw);
        valid_in = 1'b1;
        Rs1D = rs1; Rs2D = rs2; RD1D = a; RD2D = b; ImmExtD = imm;
        ALUSrcD = src; ALUControlD = op; RdD = rd; RegWriteD = rw;
        PCD = a ^ 32'h0000_1000; ResultSrcD = 2'b01;
    endtask

    // Presents one instruction, optionally with ready_in low for `stall` cycles, and records the expectation.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                        input logic src, input logic [2:0] op, input logic [AW-1:0] rd,
                        input logic rw, input int stall);
        exp_t e;
        load_d(rd + 5'd1, rd + 5'd2, a, b, imm, src, op, rd, rw);
        e.a = a; e.b = src ? imm : b; e.wd = b; e.pc = a ^ 32'h0000_1000;
        e.op = op; e.rd = rd; e.rw = rw;
        sb_q.push_back(e);
        ready_in = (stall == 0);
        for (int i = 0; i < stall; i++) next_cycle();
        ready_in = 1'b1;
        next_cycle();
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1)
            $display("FAIL reset_hs: got valid_out=%0b ready_out=%0b expected 0/1", valid_out, ready_out);
        else n_pass++;
        @(negedge clk) rst = 1'b1;
        next_cycle();
        load_d(5'd1, 5'd2, 32'h9, 32'h3, 32'h44, 1'b1, 3'b010, 5'd5, 1'b1);
        ready_in = 1'b0;
        next_cycle();
        valid_in = 1'b0;
        n_total++;
        if (valid_out !== 1'b1 || RegWriteE !== 1'b1)
            $display("FAIL reset_pre_hold: got valid_out=%0b RegWriteE=%0b expected 1/1", valid_out, RegWriteE);
        else n_pass++;
        next_cycle();
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (valid_out !== 1'b0 || RegWriteE !== 1'b0 || ready_out !== 1'b1)
            $display("FAIL reset_mid_hold: got valid_out=%0b RegWriteE=%0b ready_out=%0b expected 0/0/1",
                     valid_out, RegWriteE, ready_out);
        else n_pass++;
        n_total++;
        if ({SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, RdE, ResultSrcE} !== '0)
            $display("FAIL reset_data: got A=%0h B=%0h WD=%0h PC=%0h Imm=%0h op=%0d rd=%0d rs=%0d expected all 0",
                     SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, RdE, ResultSrcE);
        else n_pass++;
        @(negedge clk) rst = 1'b1;
        ready_in = 1'b1;
        next_cycle();
    endtask

    task automatic test_basic();
        sb_en = 1'b1;
        send(32'd5, 32'd7, 32'h0, 1'b0, 3'b000, 5'd8, 1'b1, 0);
        next_cycle();
        send(32'h100, 32'h200, 32'hFFFF_FFF0, 1'b1, 3'b001, 5'd9, 1'b0, 0);
        next_cycle();
        next_cycle();
        sb_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        sb_en = 1'b1;
        send(32'h1111_0001, 32'h2222_0001, 32'h10, 1'b0, 3'b010, 5'd10, 1'b1, 0);
        send(32'h1111_0002, 32'h2222_0002, 32'h20, 1'b1, 3'b011, 5'd11, 1'b1, 0);
        send(32'h1111_0003, 32'h2222_0003, 32'h30, 1'b0, 3'b100, 5'd12, 1'b0, 3);
        send(32'h1111_0004, 32'h2222_0004, 32'h40, 1'b1, 3'b101, 5'd13, 1'b1, 0);
        next_cycle();
        next_cycle();
        n_total++;
        if (sb_q.size() !== 0 || valid_out !== 1'b0)
            $display("FAIL b2b_drain: got %0d pending, valid_out=%0b expected 0 pending, 0", sb_q.size(), valid_out);
        else n_pass++;
        sb_en = 1'b0;
    endtask

    task automatic test_forward_priority();
        load_d(5'd3, 5'd6, 32'hAAAA, 32'h1234, 32'h0, 1'b0, 3'b000, 5'd7, 1'b1);
        next_cycle();
        valid_in = 1'b0;
        RdM = 5'd3; RegWriteM = 1'b1; ALUResultM = 32'h10;
        RdW = 5'd3; RegWriteW = 1'b1; ResultW = 32'h20;
        #1;
        n_total++;
        if (SrcAE !== 32'h10) $display("FAIL fwd_m_over_w: got %0h expected 10", SrcAE);
        else n_pass++;
        n_total++;
        if (WriteDataE !== 32'h1234) $display("FAIL fwd_b_nomatch: got %0h expected 1234", WriteDataE);
        else n_pass++;
        RegWriteM = 1'b0;
        #1;
        n_total++;
        if (SrcAE !== 32'h20) $display("FAIL fwd_w: got %0h expected 20", SrcAE);
        else n_pass++;
        RegWriteW = 1'b0;
        #1;
        n_total++;
        if (SrcAE !== 32'hAAAA) $display("FAIL fwd_none: got %0h expected aaaa", SrcAE);
        else n_pass++;
        RdW = 5'd6; RegWriteW = 1'b1; ResultW = 32'h77;
        #1;
        n_total++;
        if (WriteDataE !== 32'h77 || SrcBE !== 32'h77)
            $display("FAIL fwd_b_w: got WD=%0h B=%0h expected 77/77", WriteDataE, SrcBE);
        else n_pass++;
        clear_fwd();
        next_cycle();
    endtask

    task automatic test_x0_guard();
        load_d(5'd0, 5'd0, 32'h0, 32'h0, 32'h5A5A, 1'b0, 3'b000, 5'd1, 1'b1);
        next_cycle();
        valid_in = 1'b0;
        RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'hFF;
        RdW = 5'd0; RegWriteW = 1'b1; ResultW = 32'hEE;
        #1;
        n_total++;
        if (SrcBE !== 32'h0 || WriteDataE !== 32'h0 || SrcAE !== 32'h0)
            $display("FAIL x0_guard: got A=%0h B=%0h WD=%0h expected 0/0/0", SrcAE, SrcBE, WriteDataE);
        else n_pass++;
        clear_fwd();
        next_cycle();
    endtask

    task automatic test_stall_refresh();
        load_d(5'd4, 5'd9, 32'h11, 32'h22, 32'h0, 1'b0, 3'b000, 5'd2, 1'b1);
        ready_in = 1'b0;
        next_cycle();
        valid_in = 1'b0;
        n_total++;
        if (valid_out !== 1'b1 || ready_out !== 1'b0)
            $display("FAIL stall_hold: got valid_out=%0b ready_out=%0b expected 1/0", valid_out, ready_out);
        else n_pass++;
        RdW = 5'd4; RegWriteW = 1'b1; ResultW = 32'h55;
        #1;
        n_total++;
        if (SrcAE !== 32'h55) $display("FAIL stall_fwd: got %0h expected 55", SrcAE);
        else n_pass++;
        next_cycle();
        RegWriteW = 1'b0;
        #1;
        n_total++;
        if (SrcAE !== 32'h55) $display("FAIL stall_refresh: got %0h expected 55", SrcAE);
        else n_pass++;
        next_cycle();
        n_total++;
        if (SrcAE !== 32'h55 || WriteDataE !== 32'h22)
            $display("FAIL stall_keep: got A=%0h WD=%0h expected 55/22", SrcAE, WriteDataE);
        else n_pass++;
        ready_in = 1'b1;
        #1;
        n_total++;
        if (ready_out !== 1'b1 || valid_out !== 1'b1)
            $display("FAIL stall_release: got ready_out=%0b valid_out=%0b expected 1/1", ready_out, valid_out);
        else n_pass++;
        next_cycle();
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL stall_xfer: got valid_out=%0b expected 0", valid_out);
        else n_pass++;
        clear_fwd();
    endtask

    task automatic test_flush();
        load_d(5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 1'b0, 3'b000, 5'd6, 1'b1);
        flush = 1'b1;
        next_cycle();
        valid_in = 1'b0;
        flush = 1'b0;
        n_total++;
        if (valid_out !== 1'b0 || RegWriteE !== 1'b0)
            $display("FAIL flush_accept: got valid_out=%0b RegWriteE=%0b expected 0/0", valid_out, RegWriteE);
        else n_pass++;
        load_d(5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 1'b0, 3'b000, 5'd6, 1'b1);
        ready_in = 1'b0;
        next_cycle();
        valid_in = 1'b0;
        flush = 1'b1;
        #1;
        n_total++;
        if (valid_out !== 1'b1 || ready_out !== 1'b0)
            $display("FAIL flush_hold_pre: got valid_out=%0b ready_out=%0b expected 1/0", valid_out, ready_out);
        else n_pass++;
        next_cycle();
        flush = 1'b0;
        n_total++;
        if (valid_out !== 1'b0 || RegWriteE !== 1'b0 || ready_out !== 1'b1)
            $display("FAIL flush_hold: got valid_out=%0b RegWriteE=%0b ready_out=%0b expected 0/0/1",
                     valid_out, RegWriteE, ready_out);
        else n_pass++;
        ready_in = 1'b1;
        next_cycle();
    endtask

    initial begin
        rst = 1'b0;
        valid_in = 1'b0; ready_in = 1'b1; flush = 1'b0;
        RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;
        ALUSrcD = 1'b0; ALUControlD = 3'b000; RegWriteD = 1'b0; ResultSrcD = 2'b00;
        clear_fwd();

        test_reset();
        test_basic();
        test_back_to_back();
        test_forward_priority();
        test_x0_guard();
        test_stall_refresh();
        test_flush();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
